// File: rtl/nodf_module_intf.sv
// nodf_module_intf: ap_ctrl handshake monitor counting transactions, latencies and occupancy
module nodf_module_intf #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] start_count,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] min_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic [CNT_W-1:0] busy_cycles,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] idle_cycles,
    output logic             txn_done,
    output logic             protocol_err
);
    typedef enum logic [1:0] {IDLE, BUSY, WAIT_CONT, FINISHED} state_t;
    state_t st, st_nx;
    logic [CNT_W-1:0] lat, cur_lat;
    logic complete;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + CNT_W'(1);
    endfunction

    assign state = st;

    // cur_lat is the latency including the present cycle
    always_comb begin
        cur_lat = (st == IDLE) ? CNT_W'(1) : sat_inc(lat);
        complete = (st == BUSY && ap_done && ap_continue) || (st == WAIT_CONT && ap_continue) ||
                   (st == IDLE && ap_start && ap_done && ap_continue);
        st_nx = finish ? FINISHED : complete ? IDLE : (st == IDLE) ? (ap_start ? BUSY : IDLE) :
                (st == BUSY) ? (ap_done ? WAIT_CONT : BUSY) : st;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st           <= IDLE;
            lat          <= '0;
            start_count  <= '0;
            txn_count    <= '0;
            last_latency <= '0;
            min_latency  <= '1;
            max_latency  <= '0;
            busy_cycles  <= '0;
            stall_cycles <= '0;
            idle_cycles  <= '0;
            txn_done     <= 1'b0;
            protocol_err <= 1'b0;
        end else if (st != FINISHED) begin
            st       <= st_nx;
            lat      <= cur_lat;
            txn_done <= complete;
            if (ap_start && ap_ready) start_count <= sat_inc(start_count);
            if (st == BUSY) busy_cycles <= sat_inc(busy_cycles);
            if (st == WAIT_CONT) stall_cycles <= sat_inc(stall_cycles);
            if (st == IDLE && !ap_start) idle_cycles <= sat_inc(idle_cycles);
            if (st == IDLE && !ap_start && (ap_done || ap_ready)) protocol_err <= 1'b1;
            if (complete) begin
                txn_count    <= sat_inc(txn_count);
                last_latency <= cur_lat;
                if (cur_lat < min_latency) min_latency <= cur_lat;
                if (cur_lat > max_latency) max_latency <= cur_lat;
            end
        end else begin
            txn_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_nodf_module_intf.sv
// tb_nodf_module_intf: directed stimulus against a timestamp-based reference model of the monitor
module tb_nodf_module_intf;
    localparam int W = 8;
    localparam int MAX = 255;

    logic clock, reset, ap_start, ap_ready, ap_done, ap_continue, finish;
    logic [1:0] state;
    logic [W-1:0] start_count, txn_count, last_latency, min_latency, max_latency;
    logic [W-1:0] busy_cycles, stall_cycles, idle_cycles;
    logic txn_done, protocol_err;

    nodf_module_intf #(.CNT_W(W)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .state(state),
        .start_count(start_count), .txn_count(txn_count), .last_latency(last_latency),
        .min_latency(min_latency), .max_latency(max_latency), .busy_cycles(busy_cycles),
        .stall_cycles(stall_cycles), .idle_cycles(idle_cycles), .txn_done(txn_done),
        .protocol_err(protocol_err)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: phase 0..3, latency from start timestamp rather than a running counter
    int ph, sc, tc, last, mn, mx, bc, stc, ic, td, pe, cyc, t0;

    function automatic int sat(input int x);
        return x > MAX ? MAX : x;
    endfunction

    always @(posedge clock or posedge reset) begin
        int nph, lat;
        bit fin_now;
        if (reset) begin
            ph = 0; sc = 0; tc = 0; last = 0; mn = MAX; mx = 0;
            bc = 0; stc = 0; ic = 0; td = 0; pe = 0;
        end else begin
            td = 0;
            if (ph != 3) begin
                fin_now = 0;
                nph = ph;
                if (ph == 0) begin
                    if (ap_start) begin
                        t0 = cyc;
                        fin_now = ap_done && ap_continue;
                        nph = fin_now ? 0 : 1;
                    end else begin
                        ic = sat(ic + 1);
                        if (ap_done || ap_ready) pe = 1;
                    end
                end else if (ph == 1) begin
                    bc = sat(bc + 1);
                    fin_now = ap_done && ap_continue;
                    nph = fin_now ? 0 : (ap_done ? 2 : 1);
                end else begin
                    stc = sat(stc + 1);
                    fin_now = ap_continue;
                    nph = fin_now ? 0 : 2;
                end
                if (ap_start && ap_ready) sc = sat(sc + 1);
                if (fin_now) begin
                    lat = sat(cyc - t0 + 1);
                    tc = sat(tc + 1);
                    last = lat;
                    if (lat < mn) mn = lat;
                    if (lat > mx) mx = lat;
                    td = 1;
                end
                ph = finish ? 3 : nph;
            end
            cyc++;
        end
    end

    always @(negedge clock) begin
        chk("state", int'(state), ph);
        chk("start_count", int'(start_count), sc);
        chk("txn_count", int'(txn_count), tc);
        chk("last_latency", int'(last_latency), last);
        chk("min_latency", int'(min_latency), mn);
        chk("max_latency", int'(max_latency), mx);
        chk("busy_cycles", int'(busy_cycles), bc);
        chk("stall_cycles", int'(stall_cycles), stc);
        chk("idle_cycles", int'(idle_cycles), ic);
        chk("txn_done", int'(txn_done), td);
        chk("protocol_err", int'(protocol_err), pe);
    end

    task automatic step(input logic s, input logic r, input logic d, input logic c, input logic f);
        {ap_start, ap_ready, ap_done, ap_continue, finish} = {s, r, d, c, f};
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        {ap_start, ap_ready, ap_done, ap_continue, finish} = '0;
        reset = 1;
        @(posedge clock);
        #1 reset = 0;
    endtask

    task automatic txn(input int n);
        step(1, 1, 0, 1, 0);
        repeat (n - 2) step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
    endtask

    initial begin
        cyc = 0;
        {ap_start, ap_ready, ap_done, ap_continue, finish} = '0;
        reset = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        chk("rst_state", int'(state), 0);
        chk("rst_min", int'(min_latency), 255);
        chk("rst_txn", int'(txn_count), 0);

        // single transaction, done four cycles after start
        step(1, 1, 0, 1, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        chk("t1_done", int'(txn_done), 1);
        chk("t1_last", int'(last_latency), 5);
        chk("t1_txn", int'(txn_count), 1);
        chk("t1_start", int'(start_count), 1);
        chk("t1_busy", int'(busy_cycles), 4);
        step(0, 0, 0, 1, 0);
        chk("t1_pulse", int'(txn_done), 0);

        // start and done together
        do_reset();
        step(1, 1, 1, 1, 0);
        chk("t2_state", int'(state), 0);
        chk("t2_last", int'(last_latency), 1);
        chk("t2_min", int'(min_latency), 1);
        chk("t2_max", int'(max_latency), 1);

        // stall for continue
        do_reset();
        step(1, 1, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        chk("t3_wait", int'(state), 2);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("t3_wait2", int'(state), 2);
        step(0, 0, 1, 1, 0);
        chk("t3_stall", int'(stall_cycles), 3);
        chk("t3_last", int'(last_latency), 5);
        chk("t3_state", int'(state), 0);

        // three latencies
        do_reset();
        txn(3);
        txn(7);
        txn(5);
        chk("t4_min", int'(min_latency), 3);
        chk("t4_max", int'(max_latency), 7);
        chk("t4_last", int'(last_latency), 5);
        chk("t4_txn", int'(txn_count), 3);

        // protocol error is sticky
        do_reset();
        step(0, 0, 1, 1, 0);
        chk("t5_err", int'(protocol_err), 1);
        txn(3);
        chk("t5_hold", int'(protocol_err), 1);
        do_reset();
        chk("t5_clr", int'(protocol_err), 0);
        step(0, 1, 0, 1, 0);
        chk("t5_ready", int'(protocol_err), 1);

        // finish mid-busy freezes everything
        do_reset();
        step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        chk("t6_fin", int'(state), 3);
        step(1, 1, 1, 1, 0);
        step(0, 1, 1, 0, 0);
        chk("t6_state", int'(state), 3);
        chk("t6_txn", int'(txn_count), 0);
        chk("t6_busy", int'(busy_cycles), 3);
        chk("t6_start", int'(start_count), 1);
        do_reset();
        chk("t6_rst_state", int'(state), 0);
        chk("t6_rst_busy", int'(busy_cycles), 0);
        chk("t6_rst_start", int'(start_count), 0);

        // completion coincident with finish is counted
        step(1, 1, 0, 1, 0);
        step(0, 0, 1, 1, 1);
        chk("t7_txn", int'(txn_count), 1);
        chk("t7_state", int'(state), 3);

        // reset mid-transaction discards it
        do_reset();
        step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        do_reset();
        txn(4);
        chk("t8_last", int'(last_latency), 4);
        chk("t8_txn", int'(txn_count), 1);

        // saturation
        do_reset();
        step(1, 1, 0, 1, 0);
        repeat (300) step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        chk("t9_busy", int'(busy_cycles), 255);
        chk("t9_last", int'(last_latency), 255);
        repeat (300) step(0, 0, 0, 1, 0);
        chk("t9_idle", int'(idle_cycles), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
